decode_issue_buffer: RTL and testbench
======================================

// Module: decode_issue_buffer
// PURPOSE
//  Parametrised decode-stage instruction buffer between fetch and issue/decode.
//  - Accepts up to FETCH_W instructions per cycle.
//  - Tags each entry with branch/jump class and a MIPS delay-slot flag.
//  - Presents up to ISSUE_W in-order entries per cycle under group-formation rules.
//  - Replaces the single-instruction decode register with multi-entry, multi-issue buffering.
// PARAMETERS
//  FETCH_W  2  instructions offered by fetch per cycle (1..4)
//  ISSUE_W  2  instructions presented to issue per cycle (1..4)
//  DEPTH    8  buffer entries; power of 2, >= FETCH_W + ISSUE_W
// PORTS
//  clk         in   1               clock
//  resetn      in   1               synchronous, active-low reset
//  flush       in   1               drop all entries and delay-slot state
//  in_valid    in   FETCH_W         per-slot valid; contiguous from bit 0
//  in_instr    in   32*FETCH_W      raw instruction words, slot k at [32k+:32]
//  in_pcplus4  in   32*FETCH_W      PC+4 per slot
//  in_ready    out  1               buffer can take FETCH_W entries this cycle
//  out_valid   out  ISSUE_W         presented slots; contiguous from bit 0
//  out_instr   out  32*ISSUE_W      head instructions in program order
//  out_pcplus4 out  32*ISSUE_W      PC+4 per presented slot
//  out_dslot   out  ISSUE_W         slot is a branch/jump delay slot
//  out_ctrl    out  ISSUE_W         slot is a branch or jump
//  out_take    in   $clog2(ISSUE_W+1)  number of head slots consumed this cycle
//  count       out  $clog2(DEPTH+1) occupied entries (registered)
// BEHAVIOUR
//  Reset (resetn=0 at posedge clk):
//   - Pointers and count = 0; dslot tracker = 0.
//   - in_ready = 1; out_valid = 0.
//  Control predecode (combinational, on enqueue):
//   - Opcodes 000001, 000010, 000011, 000100..000111 are control.
//   - Opcode 000000 with funct 001000 (JR) or 001001 (JALR) is control.
//  Delay-slot flag:
//   - An entry's dslot = ctrl of the immediately preceding enqueued instruction.
//   - Computed across slots within the same cycle.
//   - Across cycles via the last_ctrl register, updated on each enqueue.
//  Enqueue:
//   - in_ready = (DEPTH - count) >= FETCH_W, from registered count only.
//   - When in_ready & in_valid[0]: write popcount(in_valid) entries at tail.
//  Dequeue:
//   - out_take entries leave the head at posedge.
//   - out_take > popcount(out_valid) is illegal; assert in simulation.
//  Group formation (out_valid prefix):
//   - Slot k is valid only if slot k-1 is valid and entry k exists.
//   - A control entry is valid only if its delay slot is also buffered.
//   - If that delay slot lies beyond ISSUE_W-1, the control entry may lead only the next group.
//   - The prefix ends after a delay slot: at most one control transfer per group.
//  Simultaneous events:
//   - Enqueue and dequeue in the same cycle: count += enq - take.
//   - Pointers wrap modulo DEPTH.
//  Flush (priority over enqueue and dequeue):
//   - Next cycle: count = 0, last_ctrl = 0, out_valid = 0.
//   - Entries not yet taken, including pending delay slots, are discarded.
//  Latency: entry written at edge N is presentable from cycle N+1.
// CONFIGURATION
//  DECODE_BUF_BYPASS_EN defined:
//   - When count == 0 and no flush, incoming in_valid slots drive out_* combinationally (0-cycle latency).
//   - Group rules still apply.
//   - Bypassed slots consumed by out_take are not written.
//  DECODE_BUF_BYPASS_EN undefined: always 1-cycle latency; no in_* -> out_* combinational path.
// TESTING
//  - Reset, FETCH_W=ISSUE_W=2, hold out_take=0, enqueue 4 pairs of ALU ops
//    -> count 8, in_ready 0; 5th pair ignored.
//  - Enqueue {BEQ, ADDU}, then take 2
//    -> out_valid=11, out_ctrl=01, out_dslot=10; count returns to 0.
//  - Enqueue {ADDU, J} alone -> out_valid=01 (J withheld).
//    Next cycle enqueue {NOP, ADDU} -> J group {J, NOP}, J marked ctrl, NOP dslot=1.
//  - Buffer full (8), take 2 and enqueue 2 in the same cycle for 10 cycles
//    -> count stays 8; pointers wrap; order preserved.
//  - count=5, flush asserted with in_valid=11 -> next cycle count 0, out_valid 0, last_ctrl 0.
//  - With DECODE_BUF_BYPASS_EN: empty buffer, enqueue {ORI, ADDU}, out_take=2
//    -> same-cycle out_valid=11; count remains 0.

Source files
------------

// File: rtl/decode_issue_buffer.sv
// decode_issue_buffer
//   Multi-entry, multi-issue decode-stage instruction buffer sitting between
//   fetch and issue. Each entry carries the raw instruction, its PC+4, a
//   predecoded branch/jump flag (ctrl) and a MIPS delay-slot flag (dslot).
//
//   Handshake: fetch offers in_valid (contiguous from bit 0) every cycle; the
//   offered slots are written at the clock edge only when in_ready is high,
//   in_valid[0] is set and flush is low (in_ready never depends on in_valid).
//   Issue sees a contiguous out_valid prefix and reports in out_take how many
//   head slots it consumed; those entries leave at the same clock edge.
//   out_take may never exceed the number of presented slots.
//
//   Optional feature macro: DECODE_BUF_BYPASS_EN. When defined, an empty
//   buffer forwards the incoming fetch slots straight to out_* in the same
//   cycle, and slots consumed that cycle are never written. When undefined,
//   every entry spends at least one cycle in the buffer.
module decode_issue_buffer #(
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    parameter int DEPTH   = 8,
    localparam int TAKE_W = $clog2(ISSUE_W + 1),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   flush,
    input  logic [FETCH_W-1:0]     in_valid,
    input  logic [32*FETCH_W-1:0]  in_instr,
    input  logic [32*FETCH_W-1:0]  in_pcplus4,
    output logic                   in_ready,
    output logic [ISSUE_W-1:0]     out_valid,
    output logic [32*ISSUE_W-1:0]  out_instr,
    output logic [32*ISSUE_W-1:0]  out_pcplus4,
    output logic [ISSUE_W-1:0]     out_dslot,
    output logic [ISSUE_W-1:0]     out_ctrl,
    input  logic [TAKE_W-1:0]      out_take,
    output logic [CNT_W-1:0]       count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int FN_W  = $clog2(FETCH_W + 1);
    // The head view must be wide enough for both the issue window and the
    // incoming fetch slots (the latter only matter for the bypass path).
    localparam int VW    = (FETCH_W > ISSUE_W) ? FETCH_W : ISSUE_W;

    // Entry storage
    logic [31:0]        mem_instr [DEPTH];
    logic [31:0]        mem_pc    [DEPTH];
    logic [DEPTH-1:0]   mem_ctrl;
    logic [DEPTH-1:0]   mem_dslot;

    // Queue control state
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count_q;
    logic               last_ctrl;

    // Incoming slot predecode
    logic [FETCH_W-1:0] in_ctrl;
    logic [FETCH_W-1:0] in_dslot;
    logic [FN_W-1:0]    in_num;
    logic               last_in_ctrl;

    // Enqueue / dequeue bookkeeping
    logic               enq_fire;
    logic               byp;
    logic [TAKE_W-1:0]  skip;
    logic [CNT_W-1:0]   wr_num;
    logic [PTR_W-1:0]   head_adv;
    logic [FETCH_W-1:0] wr_en;
    logic [PTR_W-1:0]   wr_idx [FETCH_W];

    // Head view used for group formation
    logic [31:0]        v_instr [VW];
    logic [31:0]        v_pc    [VW];
    logic [VW-1:0]      v_ctrl;
    logic [VW-1:0]      v_dslot;
    logic [CNT_W-1:0]   v_avail;

    // Branches: REGIMM, J, JAL, BEQ, BNE, BLEZ, BGTZ; SPECIAL JR and JALR.
    function automatic logic is_ctrl(input logic [5:0] op, input logic [5:0] fn);
        return ((op >= 6'd1) && (op <= 6'd7)) ||
               ((op == 6'd0) && ((fn == 6'b001000) || (fn == 6'b001001)));
    endfunction

    assign count    = count_q;
    // Space check uses only the registered occupancy so in_ready has no
    // combinational dependence on fetch or issue inputs.
    assign in_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(FETCH_W);
    assign enq_fire = in_ready && in_valid[0] && !flush;

    // Predecode incoming slots and chain the delay-slot flag through them.
    always_comb begin
        in_num       = '0;
        last_in_ctrl = 1'b0;
        for (int k = 0; k < FETCH_W; k++) begin
            in_ctrl[k] = is_ctrl(in_instr[32*k+26 +: 6], in_instr[32*k +: 6]);
            if (in_valid[k]) begin
                in_num       = in_num + FN_W'(1);
                last_in_ctrl = in_ctrl[k];
            end
        end
        in_dslot[0] = last_ctrl;
        for (int k = 1; k < FETCH_W; k++) begin
            in_dslot[k] = in_ctrl[k-1];
        end
    end

`ifdef DECODE_BUF_BYPASS_EN
    assign byp = (count_q == '0) && !flush && in_ready && in_valid[0];
`else
    assign byp = 1'b0;
`endif

    // Work out how many slots are written, where, and how far the head moves.
    always_comb begin
        skip     = byp ? out_take : '0;
        wr_num   = enq_fire ? (CNT_W'(in_num) - CNT_W'(skip)) : '0;
        head_adv = byp ? '0 : PTR_W'(out_take);
        for (int k = 0; k < FETCH_W; k++) begin
            wr_en[k]  = enq_fire && in_valid[k] && (k >= int'(skip));
            wr_idx[k] = tail + PTR_W'(k) - PTR_W'(skip);
        end
    end

    // Build the head view: buffered entries, or the fetch slots when bypassing.
    always_comb begin
        v_avail = count_q;
        for (int k = 0; k < VW; k++) begin
            v_instr[k] = mem_instr[head + PTR_W'(k)];
            v_pc[k]    = mem_pc[head + PTR_W'(k)];
            v_ctrl[k]  = mem_ctrl[head + PTR_W'(k)];
            v_dslot[k] = mem_dslot[head + PTR_W'(k)];
        end
`ifdef DECODE_BUF_BYPASS_EN
        if (byp) begin
            v_avail = CNT_W'(in_num);
            for (int k = 0; k < FETCH_W; k++) begin
                v_instr[k] = in_instr[32*k +: 32];
                v_pc[k]    = in_pcplus4[32*k +: 32];
                v_ctrl[k]  = in_ctrl[k];
                v_dslot[k] = in_dslot[k];
            end
        end
`endif
    end

    // Form the issue group: a contiguous prefix where a branch only goes out
    // together with its delay slot, and the group closes after a delay slot.
    always_comb begin : group_form
        logic grp_open;
        logic ok;
        out_valid   = '0;
        out_ctrl    = '0;
        out_dslot   = '0;
        out_instr   = '0;
        out_pcplus4 = '0;
        grp_open    = 1'b1;
        for (int k = 0; k < ISSUE_W; k++) begin
            ok = grp_open && (k < int'(v_avail));
            // A branch needs its delay slot buffered and inside this window;
            // a branch in the last lane waits to lead the next group instead.
            if (ok && v_ctrl[k] && !v_dslot[k]) begin
                ok = ((k + 1) < int'(v_avail)) && (((k + 1) < ISSUE_W) || (k == 0));
            end
            out_valid[k]          = ok;
            out_ctrl[k]           = ok && v_ctrl[k];
            out_dslot[k]          = ok && v_dslot[k];
            out_instr[32*k +: 32] = v_instr[k];
            out_pcplus4[32*k +: 32] = v_pc[k];
            if (!ok || v_dslot[k]) begin
                grp_open = 1'b0;
            end
        end
    end

    // Write accepted fetch slots into the entry array (data needs no reset).
    always_ff @(posedge clk) begin
        for (int k = 0; k < FETCH_W; k++) begin
            if (wr_en[k]) begin
                mem_instr[wr_idx[k]] <= in_instr[32*k +: 32];
                mem_pc[wr_idx[k]]    <= in_pcplus4[32*k +: 32];
                mem_ctrl[wr_idx[k]]  <= in_ctrl[k];
                mem_dslot[wr_idx[k]] <= in_dslot[k];
            end
        end
    end

    // Pointer, occupancy and delay-slot tracker update; flush wins over traffic.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            head      <= '0;
            tail      <= '0;
            count_q   <= '0;
            last_ctrl <= 1'b0;
        end else if (flush) begin
            head      <= '0;
            tail      <= '0;
            count_q   <= '0;
            last_ctrl <= 1'b0;
        end else begin
            head    <= head + head_adv;
            tail    <= tail + PTR_W'(wr_num);
            count_q <= count_q + wr_num - CNT_W'(head_adv);
            if (enq_fire) begin
                last_ctrl <= last_in_ctrl;
            end
        end
    end

`ifndef SYNTHESIS
    // Issue may never consume more slots than are presented.
    take_legal: assert property (@(posedge clk) disable iff (!resetn)
        int'(out_take) <= $countones(out_valid));
`endif

endmodule

// File: tb/tb_decode_issue_buffer.sv
// tb_decode_issue_buffer
//   Directed bench for decode_issue_buffer (FETCH_W=2, ISSUE_W=2, DEPTH=8).
//   Every accepted fetch slot is pushed to exp_q with its expected ctrl and
//   dslot flags; every consumed issue slot is popped and compared.
module tb_decode_issue_buffer;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic [1:0]  in_valid;
    logic [63:0] in_instr;
    logic [63:0] in_pcplus4;
    logic        in_ready;
    logic [1:0]  out_valid;
    logic [63:0] out_instr;
    logic [63:0] out_pcplus4;
    logic [1:0]  out_dslot;
    logic [1:0]  out_ctrl;
    logic [1:0]  out_take;
    logic [3:0]  count;

    // {ctrl, dslot, pcplus4, instr}
    logic [65:0] exp_q[$];
    int          checks;
    int          failures;
    int          m_count;
    logic        m_last_ctrl;
    logic [31:0] pc_next;

    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] BEQ  = {6'b000100, 5'd1, 5'd2, 16'h0003};
    localparam logic [31:0] BLTZ = {6'b000001, 5'd3, 5'd0, 16'h0010};
    localparam logic [31:0] JMP  = {6'b000010, 26'h010_0040};
    localparam logic [31:0] JR   = {6'b000000, 5'd31, 15'h0, 6'b001000};
    localparam logic [31:0] JALR = {6'b000000, 5'd4, 5'd0, 5'd31, 5'd0, 6'b001001};
    localparam logic [31:0] ORI  = {6'b001101, 5'd0, 5'd8, 16'h1234};
    localparam logic [31:0] ADDI = {6'b001000, 5'd1, 5'd9, 16'h0007};
    localparam logic [31:0] MOVZ = {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b001010};

    decode_issue_buffer #(.FETCH_W(2), .ISSUE_W(2), .DEPTH(8)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .in_pcplus4  (in_pcplus4),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_instr   (out_instr),
        .out_pcplus4 (out_pcplus4),
        .out_dslot   (out_dslot),
        .out_ctrl    (out_ctrl),
        .out_take    (out_take),
        .count       (count)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic tb_ctrl(input logic [31:0] w);
        logic [5:0] op;
        logic [5:0] fn;
        op = w[31:26];
        fn = w[5:0];
        case (op)
            6'b000001, 6'b000010, 6'b000011, 6'b000100,
            6'b000101, 6'b000110, 6'b000111: return 1'b1;
            6'b000000: return (fn == 6'b001000) || (fn == 6'b001001);
            default: return 1'b0;
        endcase
    endfunction

    // Random ADDU rd, rs, rt
    function automatic logic [31:0] alu();
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        rs = 5'($urandom_range(31, 0));
        rt = 5'($urandom_range(31, 0));
        rd = 5'($urandom_range(31, 1));
        return {6'b000000, rs, rt, rd, 5'd0, 6'b100001};
    endfunction

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic peek(input logic [1:0] ev, input logic [1:0] ec, input logic [1:0] ed);
        chk("group_valid", out_valid, ev);
        chk("group_ctrl", out_ctrl, ec);
        chk("group_dslot", out_dslot, ed);
    endtask

    task automatic idle_inputs();
        in_valid   = 2'b00;
        in_instr   = '0;
        in_pcplus4 = '0;
        out_take   = 2'd0;
        flush      = 1'b0;
    endtask

    // One clock of traffic: drive, score consumed slots, model, clock, check count.
    task automatic step(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                        input int take, input logic fl);
        logic [31:0] p0;
        logic [31:0] p1;
        logic        c0;
        logic        c1;
        logic        acc;
        logic        pushed;
        logic [65:0] e;
        int          n;
        p0 = pc_next + 32'd4;
        p1 = pc_next + 32'd8;
        pc_next = pc_next + 32'd8;
        in_valid   = v;
        in_instr   = {i1, i0};
        in_pcplus4 = {p1, p0};
        out_take   = 2'(take);
        flush      = fl;
        #2;
        c0  = tb_ctrl(i0);
        c1  = tb_ctrl(i1);
        acc = !fl && (m_count <= 6) && v[0];
        n   = int'(v[0]) + int'(v[1]);
        chk("in_ready", in_ready, m_count <= 6);
        pushed = 1'b0;
`ifdef DECODE_BUF_BYPASS_EN
        if (acc && m_count == 0) begin
            exp_q.push_back({c0, m_last_ctrl, p0, i0});
            if (v[1]) exp_q.push_back({c1, c0, p1, i1});
            pushed = 1'b1;
        end
`endif
        for (int i = 0; i < take; i++) begin
            chk("take_valid", out_valid[i], 1'b1);
            if (exp_q.size() == 0) begin
                chk("take_underflow", 1'b0, 1'b1);
            end else begin
                e = exp_q.pop_front();
                chk("out_instr", out_instr[32*i +: 32], e[31:0]);
                chk("out_pcplus4", out_pcplus4[32*i +: 32], e[63:32]);
                chk("out_dslot", out_dslot[i], e[64]);
                chk("out_ctrl", out_ctrl[i], e[65]);
            end
        end
        if (acc && !pushed) begin
            exp_q.push_back({c0, m_last_ctrl, p0, i0});
            if (v[1]) exp_q.push_back({c1, c0, p1, i1});
        end
        if (acc) m_last_ctrl = v[1] ? c1 : c0;
        if (fl) begin
            exp_q.delete();
            m_count     = 0;
            m_last_ctrl = 1'b0;
        end else begin
            m_count = m_count + (acc ? n : 0) - take;
        end
        @(posedge clk);
        #1;
        idle_inputs();
        chk("count", count, m_count);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        m_count     = 0;
        m_last_ctrl = 1'b0;
        pc_next     = 32'h0040_0000;
        idle_inputs();

        // Reset
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", count, 4'd0);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_valid", out_valid, 2'b00);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Fill with four ALU pairs; a fifth pair must be refused
        for (int i = 0; i < 4; i++) step(2'b11, alu(), alu(), 0, 1'b0);
        chk("full_in_ready", in_ready, 1'b0);
        step(2'b11, alu(), alu(), 0, 1'b0);
        peek(2'b11, 2'b00, 2'b00);

        // Steady take-2 / offer-2 traffic across pointer wrap
        for (int i = 0; i < 10; i++) step(2'b11, alu(), alu(), 2, 1'b0);
        while (m_count > 0) step(2'b00, NOP, NOP, 2, 1'b0);

        // Branch with its delay slot in one pair
        step(2'b11, BEQ, alu(), 0, 1'b0);
        peek(2'b11, 2'b01, 2'b10);
        step(2'b00, NOP, NOP, 2, 1'b0);

        // JALR and REGIMM branches; non-control opcodes
        step(2'b11, JALR, NOP, 0, 1'b0);
        peek(2'b11, 2'b01, 2'b10);
        step(2'b11, BLTZ, alu(), 2, 1'b0);
        peek(2'b11, 2'b01, 2'b10);
        step(2'b11, ADDI, MOVZ, 2, 1'b0);
        peek(2'b11, 2'b00, 2'b00);
        step(2'b00, NOP, NOP, 2, 1'b0);

        // Jump in the last lane is withheld until its delay slot arrives
        step(2'b11, alu(), JMP, 0, 1'b0);
        peek(2'b01, 2'b00, 2'b00);
        step(2'b11, NOP, alu(), 1, 1'b0);
        peek(2'b11, 2'b01, 2'b10);
        step(2'b00, NOP, NOP, 2, 1'b0);
        peek(2'b01, 2'b00, 2'b00);
        step(2'b00, NOP, NOP, 1, 1'b0);

        // Flush with five entries and a pending delay slot
        step(2'b11, alu(), alu(), 0, 1'b0);
        step(2'b11, alu(), alu(), 0, 1'b0);
        step(2'b01, JR, NOP, 0, 1'b0);
        step(2'b11, alu(), alu(), 0, 1'b1);
        peek(2'b00, 2'b00, 2'b00);
        step(2'b11, alu(), alu(), 0, 1'b0);
        peek(2'b11, 2'b00, 2'b00);
        step(2'b00, NOP, NOP, 2, 1'b0);

`ifdef DECODE_BUF_BYPASS_EN
        // Same-cycle presentation from an empty buffer
        step(2'b11, ORI, alu(), 2, 1'b0);
        step(2'b11, alu(), BEQ, 1, 1'b0);
        step(2'b11, NOP, alu(), 0, 1'b0);
        peek(2'b11, 2'b01, 2'b10);
        step(2'b00, NOP, NOP, 2, 1'b0);
        step(2'b00, NOP, NOP, 1, 1'b0);
`endif

        chk("final_queue_empty", 66'(exp_q.size()), 66'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
